// File: rtl/eth_tx_fcs_framer_if.sv
// eth_tx_fcs_framer_if: payload write port and serializer byte port of the TX framer.
interface eth_tx_fcs_framer_if;
  logic [7:0] data;
  logic       av;
  logic       stp;
  logic       in_rdy;
  logic [7:0] txd;
  logic       tx_en;
  logic       tx_ack;
  logic       fin;
  logic       drop;
  modport master (output data, av, stp, tx_ack, input in_rdy, txd, tx_en, fin, drop);
  modport slave  (input data, av, stp, tx_ack, output in_rdy, txd, tx_en, fin, drop);
endinterface

// File: rtl/eth_tx_fcs_framer.sv
// eth_tx_fcs_framer: store-and-forward Ethernet TX framer adding preamble/SFD, pad, FCS and IFG.
module eth_tx_fcs_framer #(
  parameter int DEPTH   = 2048,
  parameter int MIN_LEN = 60,
  parameter int IFG     = 12
) (
  input logic clk,
  input logic rst,
  eth_tx_fcs_framer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] IFG_L = 11'(IFG - 1);
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG} state_t;

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  logic [7:0]    mem [DEPTH];
  logic [10:0]   lq [4];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, start_q, start_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [AW:0]   occ_q, occ_d;
  logic [10:0]   flen_q, flen_d, len_q, len_d, cnt_q, cnt_d, nbytes, cnt_inc;
  logic [1:0]    lq_wp_q, lq_wp_d, lq_rp_q, lq_rp_d;
  logic [2:0]    fcnt_q, fcnt_d;
  logic [7:0]    txd_q, txd_d, rdata, fcs_b;
  logic [31:0]   crc_q, crc_d, crc_b;
  logic          ovf_q, ovf_d, drop_q, drop_d, fin_q, fin_d, tx_en_q, tx_en_d;
  logic          rdy, wr, discard, push, pop, free, last, go;
  state_t        st_q, st_d;

  assign rdy        = occ_q < DEPTH_L;
  assign bus.in_rdy = rdy;
  assign bus.txd    = txd_q;
  assign bus.tx_en  = tx_en_q;
  assign bus.fin    = fin_q;
  assign bus.drop   = drop_q;

  always_comb begin
    wr       = bus.av && rdy;
    nbytes   = flen_q + 11'(wr);
    discard  = bus.stp && (ovf_q || (bus.av && !rdy) || (nbytes != 11'd0 && fcnt_q == 3'd4));
    push     = bus.stp && !discard && nbytes != 11'd0;
    free     = st_q == S_DATA && bus.tx_ack;
    wr_ptr_d = discard ? start_q : wr_ptr_q + AW'(wr);
    start_d  = push ? wr_ptr_q + AW'(wr) : start_q;
    flen_d   = (discard || push) ? 11'd0 : nbytes;
    occ_d    = occ_q + (AW+1)'(wr) - (AW+1)'(free) - (discard ? (AW+1)'(nbytes) : '0);
    ovf_d    = !discard && (ovf_q || (bus.av && !rdy));
    drop_d   = discard;
    lq_wp_d  = lq_wp_q + 2'(push);
    st_d     = st_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    crc_d    = crc_q;
    txd_d    = txd_q;
    tx_en_d  = tx_en_q;
    fin_d    = 1'b0;
    last     = 1'b0;
    rd_nxt   = rd_ptr_q + AW'(1);
    rd_ptr_d = rd_ptr_q + AW'(free);
    rdata    = mem[st_q == S_DATA ? rd_nxt : rd_ptr_q];
    cnt_inc  = cnt_q + 11'd1;
    crc_b    = crc8(crc_q, txd_q);
    fcs_b    = 8'(~crc_q >> {cnt_q[1:0] + 2'd1, 3'd0});
    case (st_q)
      S_PRE: if (bus.tx_ack) begin
        st_d  = cnt_q == 11'd6 ? S_SFD : S_PRE;
        txd_d = cnt_q == 11'd6 ? 8'hD5 : 8'h55;
        cnt_d = cnt_inc;
      end
      S_SFD: if (bus.tx_ack) begin
        st_d  = S_DATA;
        txd_d = rdata;
        cnt_d = '0;
      end
      S_DATA, S_PAD: if (bus.tx_ack) begin
        last  = st_q == S_PAD || cnt_inc == len_q;
        crc_d = crc_b;
        st_d  = !last ? S_DATA : cnt_inc >= MIN_L ? S_FCS : S_PAD;
        txd_d = !last ? rdata : cnt_inc >= MIN_L ? ~crc_b[7:0] : 8'h00;
        cnt_d = (last && cnt_inc >= MIN_L) ? 11'd0 : cnt_inc;
      end
      S_FCS: if (bus.tx_ack) begin
        st_d    = cnt_q[1:0] == 2'd3 ? S_IFG : S_FCS;
        txd_d   = cnt_q[1:0] == 2'd3 ? 8'h00 : fcs_b;
        tx_en_d = cnt_q[1:0] != 2'd3;
        fin_d   = cnt_q[1:0] == 2'd3;
        cnt_d   = cnt_q[1:0] == 2'd3 ? 11'd0 : cnt_inc;
      end
      S_IFG: if (bus.tx_ack) begin
        st_d  = cnt_q == IFG_L ? S_IDLE : S_IFG;
        cnt_d = cnt_inc;
      end
      default: ;
    endcase
    // a frame already queued starts straight out of the gap, so the gap is exactly IFG byte times
    go = (st_q == S_IDLE || (st_q == S_IFG && bus.tx_ack && cnt_q == IFG_L)) && fcnt_q != 3'd0;
    pop = go;
    if (go) begin
      st_d    = S_PRE;
      len_d   = lq[lq_rp_q];
      crc_d   = '1;
      cnt_d   = '0;
      txd_d   = 8'h55;
      tx_en_d = 1'b1;
    end
    lq_rp_d = lq_rp_q + 2'(pop);
    fcnt_d  = fcnt_q + 3'(push) - 3'(pop);
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q] <= bus.data;
    if (push) lq[lq_wp_q] <= nbytes;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      start_q  <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      flen_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      lq_wp_q  <= '0;
      lq_rp_q  <= '0;
      fcnt_q   <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= 1'b0;
      fin_q    <= 1'b0;
      tx_en_q  <= 1'b0;
      txd_q    <= '0;
      crc_q    <= '1;
      st_q     <= S_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      start_q  <= start_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      flen_q   <= flen_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      lq_wp_q  <= lq_wp_d;
      lq_rp_q  <= lq_rp_d;
      fcnt_q   <= fcnt_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      fin_q    <= fin_d;
      tx_en_q  <= tx_en_d;
      txd_q    <= txd_d;
      crc_q    <= crc_d;
      st_q     <= st_d;
    end
  end
endmodule

// File: tb/tb_eth_tx_fcs_framer.sv
// tb_eth_tx_fcs_framer: scoreboard bench driving three framer configurations through one muxed port.
module tb_eth_tx_fcs_framer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [7:0] data = '0;
  logic av = 1'b0, stp = 1'b0, ack = 1'b0;
  int sel = 0, ack_div = 1, cyc = 0, rdy_lim = 1000;
  int n_tests = 0, n_fail = 0, fin_cnt = 0, drop_cnt = 0, gap_cnt = 0, gaps_seen = 0, tx_bytes = 0;
  bit gap_on = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] pl[$];
  logic [7:0] m_txd;
  logic m_en, m_fin, m_drop, m_rdy;

  eth_tx_fcs_framer_if i0 ();
  eth_tx_fcs_framer_if i1 ();
  eth_tx_fcs_framer_if i2 ();
  assign i0.data = data;
  assign i1.data = data;
  assign i2.data = data;
  assign i0.av = av && sel == 0;
  assign i1.av = av && sel == 1;
  assign i2.av = av && sel == 2;
  assign i0.stp = stp && sel == 0;
  assign i1.stp = stp && sel == 1;
  assign i2.stp = stp && sel == 2;
  assign i0.tx_ack = ack;
  assign i1.tx_ack = ack;
  assign i2.tx_ack = ack;

  eth_tx_fcs_framer #(.DEPTH(128), .MIN_LEN(0), .IFG(12)) u0 (.clk(clk), .rst(rst), .bus(i0));
  eth_tx_fcs_framer #(.DEPTH(2048), .MIN_LEN(60), .IFG(12)) u1 (.clk(clk), .rst(rst), .bus(i1));
  eth_tx_fcs_framer #(.DEPTH(16), .MIN_LEN(0), .IFG(12)) u2 (.clk(clk), .rst(rst), .bus(i2));

  always_comb begin
    m_txd  = sel == 0 ? i0.txd : sel == 1 ? i1.txd : i2.txd;
    m_en   = sel == 0 ? i0.tx_en : sel == 1 ? i1.tx_en : i2.tx_en;
    m_fin  = sel == 0 ? i0.fin : sel == 1 ? i1.fin : i2.fin;
    m_drop = sel == 0 ? i0.drop : sel == 1 ? i1.drop : i2.drop;
    m_rdy  = sel == 0 ? i0.in_rdy : sel == 1 ? i1.in_rdy : i2.in_rdy;
  end

  always @(posedge clk) begin
    #1 cyc++;
    ack = (cyc % ack_div) == 0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) r = (r >> 1) ^ ((r[0] ^ b[k]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  // lit != 0 supplies a known FCS instead of the software CRC model
  task automatic push_exp(input int min_len, input logic [31:0] lit);
    logic [31:0] c;
    int n;
    c = '1;
    n = 0;
    for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (pl[k]) begin
      exp_q.push_back(pl[k]);
      c = crc_upd(c, pl[k]);
      n++;
    end
    while (n < min_len) begin
      exp_q.push_back(8'h00);
      c = crc_upd(c, 8'h00);
      n++;
    end
    c = lit != 0 ? lit : ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
  endtask

  task automatic send(input bit stp_last);
    foreach (pl[k]) begin
      @(posedge clk); #1;
      chk("in_rdy", 32'(m_rdy), 32'(k < rdy_lim));
      data = pl[k];
      av = 1'b1;
      stp = stp_last && k == pl.size() - 1;
    end
    if (!stp_last) begin
      @(posedge clk); #1;
      av = 1'b0;
      stp = 1'b1;
    end
    @(posedge clk); #1;
    av = 1'b0;
    stp = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(posedge clk);
    chk("drained", 32'(exp_q.size()), 0);
    repeat (20 * ack_div) @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input int base, input int step);
    pl.delete();
    for (int k = 0; k < n; k++) pl.push_back(8'(base + k * step));
  endtask

  always @(negedge clk) if (!rst) begin
    if (m_fin) begin
      fin_cnt++;
      gap_on = exp_q.size() > 0;
      gap_cnt = 0;
    end
    if (m_drop) drop_cnt++;
    if (m_en) begin
      if (gap_on) begin
        chk("ifg", 32'(gap_cnt), 12);
        gap_on = 1'b0;
        gaps_seen++;
      end
      if (exp_q.size() == 0) chk("tx_unexpected", 32'(exp_q.size()), 1);
      else begin
        chk("txd", 32'(m_txd), 32'(exp_q[0]));
        if (ack) begin
          void'(exp_q.pop_front());
          tx_bytes++;
        end
      end
    end else if (ack && gap_on) gap_cnt++;
  end

  initial begin
    int f0, d0, g0, b0;
    repeat (3) @(posedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_txd", 32'(m_txd), 0);
      chk("rst_tx_en", 32'(m_en), 0);
      chk("rst_fin", 32'(m_fin), 0);
      chk("rst_drop", 32'(m_drop), 0);
      chk("rst_in_rdy", 32'(m_rdy), 1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sel = 0;
    // basic 9-byte frame with a known FCS
    load(9, 8'h31, 1);
    f0 = fin_cnt;
    push_exp(0, 32'hCBF43926);
    send(1'b1);
    drain();
    chk("s1_fin", 32'(fin_cnt - f0), 1);
    // two frames, second committed while the first is in DATA
    f0 = fin_cnt;
    g0 = gaps_seen;
    load(20, 3, 7);
    push_exp(0, 0);
    send(1'b1);
    load(15, 8'hF0, 13);
    push_exp(0, 0);
    send(1'b0);
    drain();
    chk("s5_fin", 32'(fin_cnt - f0), 2);
    chk("s5_gap_seen", 32'(gaps_seen - g0), 1);
    // sparse acknowledges
    ack_div = 4;
    load(9, 8'h31, 1);
    f0 = fin_cnt;
    push_exp(0, 32'hCBF43926);
    send(1'b0);
    drain();
    chk("s3_fin", 32'(fin_cnt - f0), 1);
    ack_div = 1;
    // padding to minimum length
    sel = 1;
    load(1, 8'hAA, 0);
    f0 = fin_cnt;
    b0 = tx_bytes;
    push_exp(60, 0);
    send(1'b1);
    drain();
    chk("s2_fin", 32'(fin_cnt - f0), 1);
    chk("s2_len", 32'(tx_bytes - b0), 72);
    // overflow discard on a 16-byte buffer
    sel = 2;
    rdy_lim = 16;
    load(20, 8'h10, 1);
    f0 = fin_cnt;
    d0 = drop_cnt;
    send(1'b0);
    repeat (30) @(posedge clk);
    chk("s4_drop", 32'(drop_cnt - d0), 1);
    chk("s4_no_fin", 32'(fin_cnt - f0), 0);
    @(posedge clk); #1;
    stp = 1'b1;
    @(posedge clk); #1;
    stp = 1'b0;
    repeat (30) @(posedge clk);
    chk("s4_empty_stp", 32'(drop_cnt - d0), 1);
    rdy_lim = 1000;
    load(5, 8'h5A, 3);
    push_exp(0, 0);
    send(1'b1);
    drain();
    chk("s4_fin", 32'(fin_cnt - f0), 1);
    // reset in the middle of a long frame
    sel = 0;
    load(100, 1, 1);
    push_exp(0, 0);
    send(1'b1);
    for (int k = 0; k < 1000 && exp_q.size() >= 60; k++) @(posedge clk);
    chk("s6_in_data", 32'(exp_q.size() < 60), 1);
    #1 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("s6_rst_tx_en", 32'(m_en), 0);
      chk("s6_rst_in_rdy", 32'(m_rdy), 1);
    end
    exp_q.delete();
    gap_on = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    load(9, 8'h31, 1);
    f0 = fin_cnt;
    push_exp(0, 32'hCBF43926);
    send(1'b1);
    drain();
    chk("s6_fin", 32'(fin_cnt - f0), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
